// File: rtl/ovr_i_pkg.sv
// Shared types and default constants for the overcurrent shutdown supervisor.
package ovr_i_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SAMPLE,
    TRIPPED
  } state_t;

  localparam int BLANK_CYC_DEF = 128;
  localparam int ERR_MAX_DEF   = 8;
  localparam int ERR_W_DEF     = 4;

endpackage

// File: rtl/ovr_i_side_filter.sv
// Per-side overcurrent filter: pin synchronizer, per-period error latch,
// leaky error counter and sticky trip flag.
module ovr_i_side_filter #(
  parameter int ERR_MAX = 8,
  parameter int ERR_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ovr_pin,
  input  logic             sample_en,
  input  logic             period_close,
  input  logic             clr_seen,
  input  logic             clr_all,
  output logic             ovr_sync,
  output logic [ERR_W-1:0] err_cnt,
  output logic             shtdwn,
  output logic             trip
);

  logic             sync_ff1;
  logic             err_seen;
  logic             seen_eff;
  logic [ERR_W-1:0] cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_ff1 <= 1'b0;
      ovr_sync <= 1'b0;
    end else begin
      sync_ff1 <= ovr_pin;
      ovr_sync <= sync_ff1;
    end
  end

  // The closing PWM_synch cycle still counts as a sampled clock of the period.
  always_comb begin
    seen_eff = err_seen | (sample_en & ovr_sync);
    cnt_nxt  = err_cnt;
    if (seen_eff) begin
      if (err_cnt != {ERR_W{1'b1}})
        cnt_nxt = err_cnt + 1'b1;
    end else if (err_cnt != '0) begin
      cnt_nxt = err_cnt - 1'b1;
    end
    trip = period_close & (cnt_nxt == ERR_W'(ERR_MAX));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_seen <= 1'b0;
      err_cnt  <= '0;
      shtdwn   <= 1'b0;
    end else begin
      if (clr_all || clr_seen || period_close)
        err_seen <= 1'b0;
      else if (sample_en && ovr_sync)
        err_seen <= 1'b1;

      if (clr_all)
        err_cnt <= '0;
      else if (period_close)
        err_cnt <= cnt_nxt;

      if (clr_all)
        shtdwn <= 1'b0;
      else if (trip)
        shtdwn <= 1'b1;
    end
  end

endmodule

// File: rtl/ovr_i_shtdwn_ctrl.sv
// Overcurrent shutdown supervisor: shared blanking FSM plus two side filters.
// Optional macro OVR_I_CLR_EN enables clearing a trip via clr_shtdwn.
module ovr_i_shtdwn_ctrl
  import ovr_i_pkg::*;
#(
  parameter int BLANK_CYC = BLANK_CYC_DEF,
  parameter int ERR_MAX   = ERR_MAX_DEF,
  parameter int ERR_W     = ERR_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwr_up,
  input  logic             PWM_synch,
  input  logic             OVR_I_lft,
  input  logic             OVR_I_rght,
  input  logic             clr_shtdwn,
  output logic             OVR_I_shtdwn,
  output logic             shtdwn_lft,
  output logic             shtdwn_rght,
  output logic [ERR_W-1:0] err_cnt_lft,
  output logic [ERR_W-1:0] err_cnt_rght
);

  localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYC - 1);

  state_t          state, state_nxt;
  logic [BW-1:0]   blank_cnt, blank_nxt;
  logic            sample_en, period_close, clr_seen, clr_all;
  logic            sync_lft, sync_rght, trip_lft, trip_rght;

  assign sample_en    = (state == SAMPLE) & pwr_up;
  assign period_close = sample_en & PWM_synch;
  assign clr_seen     = (state == SAMPLE) & ~pwr_up;

`ifdef OVR_I_CLR_EN
  assign clr_all = (state == TRIPPED) & clr_shtdwn & ~sync_lft & ~sync_rght;
`else
  logic unused_clr;
  assign clr_all    = 1'b0;
  assign unused_clr = ^{clr_shtdwn, sync_lft, sync_rght};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      blank_cnt <= '0;
    end else begin
      state     <= state_nxt;
      blank_cnt <= blank_nxt;
    end
  end

  // A PWM_synch during blanking restarts the window without touching counters.
  always_comb begin
    state_nxt = state;
    blank_nxt = blank_cnt;
    case (state)
      IDLE: begin
        if (PWM_synch && pwr_up) begin
          state_nxt = BLANK;
          blank_nxt = '0;
        end
      end
      BLANK: begin
        if (!pwr_up)
          state_nxt = IDLE;
        else if (PWM_synch)
          blank_nxt = '0;
        else if (blank_cnt == BLANK_LAST)
          state_nxt = SAMPLE;
        else
          blank_nxt = blank_cnt + 1'b1;
      end
      SAMPLE: begin
        if (!pwr_up) begin
          state_nxt = IDLE;
        end else if (PWM_synch) begin
          blank_nxt = '0;
          state_nxt = (trip_lft || trip_rght) ? TRIPPED : BLANK;
        end
      end
      TRIPPED: begin
        if (clr_all)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      OVR_I_shtdwn <= 1'b0;
    else if (clr_all)
      OVR_I_shtdwn <= 1'b0;
    else if (trip_lft || trip_rght)
      OVR_I_shtdwn <= 1'b1;
  end

  ovr_i_side_filter #(.ERR_MAX(ERR_MAX), .ERR_W(ERR_W)) u_lft (
    .clk          (clk),
    .rst          (rst),
    .ovr_pin      (OVR_I_lft),
    .sample_en    (sample_en),
    .period_close (period_close),
    .clr_seen     (clr_seen),
    .clr_all      (clr_all),
    .ovr_sync     (sync_lft),
    .err_cnt      (err_cnt_lft),
    .shtdwn       (shtdwn_lft),
    .trip         (trip_lft)
  );

  ovr_i_side_filter #(.ERR_MAX(ERR_MAX), .ERR_W(ERR_W)) u_rght (
    .clk          (clk),
    .rst          (rst),
    .ovr_pin      (OVR_I_rght),
    .sample_en    (sample_en),
    .period_close (period_close),
    .clr_seen     (clr_seen),
    .clr_all      (clr_all),
    .ovr_sync     (sync_rght),
    .err_cnt      (err_cnt_rght),
    .shtdwn       (shtdwn_rght),
    .trip         (trip_rght)
  );

endmodule
